mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised MEM pipeline stage for the RISC-V core, sitting between the EX/MEM and MEM/WB registers. It holds the word-organised data memory and supports byte/halfword/word loads and stores with sign/zero extension selected by funct3. It adds a configurable wait-state controller that stalls the pipeline for multi-cycle memories, and it owns the MEM/WB register.

## Interface
Parameters:
- DEPTH, 1024: data memory size in 32-bit words; power of two, ≥2.
- ADDR_W, $clog2(DEPTH): word-index width; derived, not overridden.
- WAIT_STATES, 0: extra cycles per load/store; legal range 0..7.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write  in  1 each  EX/MEM control.
- EX_MEM_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010.
- EX_MEM_alu_out  in  32  byte address.
- EX_MEM_dataB  in  32  store data (low bytes used for B/H).
- EX_MEM_rd  in  5  destination register.
- MEM_WB_reg_write, MEM_WB_mem_to_reg  out  1 each  registered control.
- MEM_WB_mem_data, MEM_WB_alu_out  out  32 each  registered load data and ALU result.
- MEM_WB_rd  out  5  registered rd.
- mem_data  out  32  combinational extended load data; 0 unless a load completes this cycle.
- mem_stall  out  1  high while an access waits; upstream holds all EX_MEM inputs stable.
- mem_fault  out  1  combinational; high on the completing cycle of a faulting access.

## Operation
- Word index = alu_out[ADDR_W+1:2]; byte offset = alu_out[1:0]. Out-of-range if alu_out[31:ADDR_W+2] ≠ 0.
- Stores write byte lanes only: SB writes lane offset, SH lanes offset and offset+1, SW all four.
- Loads: B/H sign-extend, BU/HU zero-extend, W passes through.
- Read and write both high: write wins, mem_data = 0.
- Out-of-range: store dropped, load returns 0, mem_fault = 1.
- Unlisted funct3 on a load/store is treated as W.
- FSM states: IDLE and WAIT; a 3-bit down-counter runs in WAIT.
  - IDLE with an access and WAIT_STATES>0: load counter with WAIT_STATES−1, go to WAIT, assert mem_stall.
  - WAIT with counter>0: decrement, keep mem_stall.
  - WAIT with counter=0: complete, deassert mem_stall, return to IDLE.
  - WAIT_STATES=0: every access completes in IDLE and the FSM never leaves it.
- The store commits exactly once, on the completing edge.
- While mem_stall=1, the MEM/WB register loads a bubble: reg_write=0, mem_to_reg=0, data/alu_out/rd = 0.
- On non-stall cycles it captures EX_MEM_* and mem_data.

## Timing
- Reset (synchronous): all MEM_WB_* = 0, FSM to IDLE, counter = 0, memory word i = i.
- Combinational outputs after reset: mem_stall = 0, mem_fault = 0, mem_data = 0.
- Access latency is WAIT_STATES+1 cycles. mem_stall is high for the first WAIT_STATES of them.
- Load result appears on MEM_WB_mem_data one edge after the completing cycle.
- Back-to-back accesses: a new access is accepted in the cycle after completion.
- Reset mid-WAIT: the pending store is dropped, and mem_stall is 0 after the reset edge.
- A non-memory instruction never stalls.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - H/HU with offset[0]=1, or W with offset≠0, is misaligned.
  - A misaligned store is suppressed, a misaligned load returns 0, and mem_fault = 1.
- Undefined: offset bits below the access size are ignored (forced aligned) and never fault; only out-of-range raises mem_fault.

## Structure
- Package mem_access_pkg holds:
  - funct3 enum (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - FSM state enum;
  - MAX_WAIT_STATES = 7;
  - functions for byte-lane mask generation and load extension.
- Sub-module data_ram: DEPTH×32 array with a 4-bit byte-enable write port, asynchronous read, and synchronous reset initialisation to the word index.
- FSM, fault logic and the MEM/WB register live in mem_access_unit.

## Test plan
- Reset, then LW at 0x10 with WAIT_STATES=0 → mem_data=0x4; next edge MEM_WB_mem_data=0x4 and mem_stall never rises.
- SB dataB=0x000000F0 at 0x21, then LB at 0x21 → 0xFFFFFFF0; LBU at 0x21 → 0x000000F0; word 8 reads 0x0000F008.
- WAIT_STATES=3, SW 0xDEADBEEF at 0x40 → mem_stall high 3 cycles with MEM_WB bubbles, one write commits; LW 0x40 → 0xDEADBEEF after 4 cycles.
- LH at 0x02 after SH 0x8001 at 0x02 → 0xFFFF8001; LHU → 0x00008001.
- Macro defined: LW at 0x05 → mem_fault=1, mem_data=0; SW at 0x05 leaves word 1 = 0x1. Macro undefined: LW 0x05 → 0x1, no fault.
- Out-of-range SW at DEPTH*4 → mem_fault=1, memory unchanged. Reset asserted during WAIT of a store → store absent and MEM_WB_* = 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - access-size encodings, FSM states and lane/extension helpers for the MEM stage
package mem_access_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

  localparam int MAX_WAIT_STATES = 7;

  // Halfwords and words snap to their natural boundary; bytes use the full offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      LS_B, LS_BU: lane_mask = 4'b0001 << offset;
      LS_H, LS_HU: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default:     lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      LS_B, LS_BU: store_data = {4{data[7:0]}};
      LS_H, LS_HU: store_data = {2{data[15:0]}};
      default:     store_data = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] word,
                                              input logic [1:0] offset);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {offset, 3'b000});
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      LS_B:    load_extend = {{24{b[7]}}, b};
      LS_BU:   load_extend = {24'd0, b};
      LS_H:    load_extend = {{16{h[15]}}, h};
      LS_HU:   load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_data_ram.sv
// rtl/mem_access_unit_data_ram.sv - word-organised data RAM, byte-enable write, async read
// Reset loads each word with its own index.
module data_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'(i);
      end
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISC-V MEM stage: data RAM access, wait-state stall FSM, MEM/WB register
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being forced aligned.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_write,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [31:0] EX_MEM_alu_out,
  input  logic [31:0] EX_MEM_dataB,
  input  logic [4:0]  EX_MEM_rd,
  output logic        MEM_WB_reg_write,
  output logic        MEM_WB_mem_to_reg,
  output logic [31:0] MEM_WB_mem_data,
  output logic [31:0] MEM_WB_alu_out,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] mem_data,
  output logic        mem_stall,
  output logic        mem_fault
);

  localparam int         LP_WS       = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic       LP_HAS_WAIT = (LP_WS > 0);
  localparam logic [2:0] LP_CNT_INIT = 3'((LP_WS > 0) ? LP_WS - 1 : 0);

  mau_state_e r_state;
  logic [2:0] r_cnt;

  logic [ADDR_W-1:0] w_word_idx;
  logic [1:0]        w_offset;
  logic              w_access, w_stall, w_complete;
  logic              w_out_of_range, w_misalign, w_fault, w_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_rdata;

  assign w_word_idx     = EX_MEM_alu_out[ADDR_W+1:2];
  assign w_offset       = EX_MEM_alu_out[1:0];
  assign w_out_of_range = |(EX_MEM_alu_out >> (ADDR_W + 2));
  assign w_access       = EX_MEM_mem_read | EX_MEM_mem_write;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_comb begin
    case (EX_MEM_funct3)
      LS_B, LS_BU: w_misalign = 1'b0;
      LS_H, LS_HU: w_misalign = w_offset[0];
      default:     w_misalign = |w_offset;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // The first cycle of an access stalls straight from IDLE so latency is WAIT_STATES+1.
  assign w_stall    = LP_HAS_WAIT && (((r_state == ST_IDLE) && w_access) ||
                                      ((r_state == ST_WAIT) && (r_cnt != 3'd0)));
  assign w_complete = w_access & ~w_stall;
  assign w_fault    = w_complete & (w_out_of_range | w_misalign);
  assign w_we       = w_complete & EX_MEM_mem_write & ~w_fault;
  assign w_be       = lane_mask(EX_MEM_funct3, w_offset);
  assign w_wdata    = store_data(EX_MEM_funct3, EX_MEM_dataB);

  assign mem_stall = w_stall;
  assign mem_fault = w_fault;
  assign mem_data  = (w_complete && EX_MEM_mem_read && !EX_MEM_mem_write && !w_fault)
                     ? load_extend(EX_MEM_funct3, w_rdata, w_offset) : 32'd0;

  data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_word_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LP_HAS_WAIT && w_access) begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || w_stall) begin
      MEM_WB_reg_write  <= 1'b0;
      MEM_WB_mem_to_reg <= 1'b0;
      MEM_WB_mem_data   <= 32'd0;
      MEM_WB_alu_out    <= 32'd0;
      MEM_WB_rd         <= 5'd0;
    end else begin
      MEM_WB_reg_write  <= EX_MEM_reg_write;
      MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
      MEM_WB_mem_data   <= mem_data;
      MEM_WB_alu_out    <= EX_MEM_alu_out;
      MEM_WB_rd         <= EX_MEM_rd;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench: zero-wait and three-wait instances on shared stimulus
module tb_mem_access_unit;
  localparam int DEPTH = 1024;
  localparam int WS    = 3;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] dataB;
    logic [4:0]  rd;
  } ex_t;

  typedef struct {
    ex_t         op;
    logic [31:0] exp_md;
    logic        exp_fault;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ex_t  ex = '0;

  logic        rw0, m2r0, stall0, fault0, rw3, m2r3, stall3, fault3;
  logic [31:0] wmd0, walu0, md0, wmd3, walu3, md3;
  logic [4:0]  wrd0, wrd3;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_mem_to_reg(ex.mem_to_reg), .EX_MEM_reg_write(ex.reg_write),
    .EX_MEM_mem_read(ex.mem_read), .EX_MEM_mem_write(ex.mem_write),
    .EX_MEM_funct3(ex.funct3), .EX_MEM_alu_out(ex.alu_out), .EX_MEM_dataB(ex.dataB), .EX_MEM_rd(ex.rd),
    .MEM_WB_reg_write(rw0), .MEM_WB_mem_to_reg(m2r0), .MEM_WB_mem_data(wmd0),
    .MEM_WB_alu_out(walu0), .MEM_WB_rd(wrd0), .mem_data(md0), .mem_stall(stall0), .mem_fault(fault0)
  );

  mem_access_unit #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_mem_to_reg(ex.mem_to_reg), .EX_MEM_reg_write(ex.reg_write),
    .EX_MEM_mem_read(ex.mem_read), .EX_MEM_mem_write(ex.mem_write),
    .EX_MEM_funct3(ex.funct3), .EX_MEM_alu_out(ex.alu_out), .EX_MEM_dataB(ex.dataB), .EX_MEM_rd(ex.rd),
    .MEM_WB_reg_write(rw3), .MEM_WB_mem_to_reg(m2r3), .MEM_WB_mem_data(wmd3),
    .MEM_WB_alu_out(walu3), .MEM_WB_rd(wrd3), .mem_data(md3), .mem_stall(stall3), .mem_fault(fault3)
  );

  int          checks = 0;
  int          failures = 0;
  int          op_no = 0;
  logic [31:0] mdl_mem [DEPTH];
  logic        pend = 1'b0;
  logic [70:0] pend_wb0, pend_wb3;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s op=%0d act=%h exp=%h", name, op_no, act, exp);
    end
  endtask

  // Reference model: plain byte arithmetic over a word array.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic mdl_fault(input ex_t x);
    if (!(x.mem_read || x.mem_write)) return 1'b0;
    if (x.alu_out >= 32'(DEPTH * 4)) return 1'b1;
    if (TRAP && (int'(x.alu_out[1:0]) % acc_size(x.funct3) != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_md(input ex_t x);
    int sz, off, n;
    logic [31:0] v, m;
    if (!x.mem_read || x.mem_write || mdl_fault(x)) return 32'd0;
    sz  = acc_size(x.funct3);
    off = int'(x.alu_out[1:0]);
    off = off - (off % sz);
    v   = mdl_mem[int'(x.alu_out >> 2)] >> (8 * off);
    n   = 8 * sz;
    if (n < 32) begin
      m = (32'h1 << n) - 32'h1;
      v = v & m;
      if ((x.funct3 == 3'b000 || x.funct3 == 3'b001) && v[n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic mdl_store(input ex_t x);
    int sz, off, idx;
    if (!x.mem_write || mdl_fault(x)) return;
    sz  = acc_size(x.funct3);
    off = int'(x.alu_out[1:0]);
    off = off - (off % sz);
    idx = int'(x.alu_out >> 2);
    for (int k = 0; k < sz; k++) mdl_mem[idx][8*(off+k) +: 8] = x.dataB[8*k +: 8];
  endtask

  task automatic mdl_init();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'(i);
  endtask

  function automatic ex_t mk(input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdst);
    ex_t x;
    x.mem_to_reg = r;
    x.reg_write  = !w;
    x.mem_read   = r;
    x.mem_write  = w;
    x.funct3     = f3;
    x.alu_out    = a;
    x.dataB      = d;
    x.rd         = rdst;
    return x;
  endfunction

  task automatic add(input ex_t x, input logic [31:0] md, input logic f);
    vec_t v;
    v.op = x;
    v.exp_md = md;
    v.exp_fault = f;
    tbl.push_back(v);
  endtask

  task automatic check_pending();
    if (pend) begin
      chk("wb0", {rw0, m2r0, wmd0, walu0, wrd0}, pend_wb0);
      chk("wb3", {rw3, m2r3, wmd3, walu3, wrd3}, pend_wb3);
    end
  endtask

  task automatic step(input ex_t x, input logic st3, input logic [31:0] md_0, input logic [31:0] md_3,
                      input logic f_0, input logic f_3);
    @(negedge clk);
    check_pending();
    ex = x;
    #1;
    chk("stall0", stall0, 1'b0);
    chk("stall3", stall3, st3);
    chk("md0", md0, md_0);
    chk("md3", md3, md_3);
    chk("fault0", fault0, f_0);
    chk("fault3", fault3, f_3);
    pend_wb0 = {x.reg_write, x.mem_to_reg, md_0, x.alu_out, x.rd};
    pend_wb3 = st3 ? 71'd0 : {x.reg_write, x.mem_to_reg, md_3, x.alu_out, x.rd};
    pend = 1'b1;
  endtask

  // Each access is held WS+1 cycles: the zero-wait unit completes every cycle, the other only on the last.
  task automatic run_op(input ex_t x, input logic [31:0] md, input logic f);
    op_no++;
    if (!(x.mem_read || x.mem_write)) begin
      step(x, 1'b0, md, md, 1'b0, 1'b0);
    end else begin
      for (int c = 0; c <= WS; c++) begin
        step(x, c < WS, md, (c == WS) ? md : 32'd0, f, (c == WS) ? f : 1'b0);
      end
    end
    mdl_store(x);
  endtask

  initial begin
    ex_t         x;
    int          kind;
    logic [2:0]  ld_f3 [8];
    logic [2:0]  st_f3 [6];

    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

    add(mk(1, 0, 3'b010, 32'h10, 0, 1), 32'h4, 0);
    add(mk(0, 1, 3'b000, 32'h21, 32'hF0, 0), 32'h0, 0);
    add(mk(1, 0, 3'b000, 32'h21, 0, 2), 32'hFFFFFFF0, 0);
    add(mk(1, 0, 3'b100, 32'h21, 0, 3), 32'h000000F0, 0);
    add(mk(1, 0, 3'b010, 32'h20, 0, 4), 32'h0000F008, 0);
    add(mk(0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 0), 32'h0, 0);
    add(mk(1, 0, 3'b010, 32'h40, 0, 5), 32'hDEADBEEF, 0);
    add(mk(0, 1, 3'b001, 32'h02, 32'h00008001, 0), 32'h0, 0);
    add(mk(1, 0, 3'b001, 32'h02, 0, 6), 32'hFFFF8001, 0);
    add(mk(1, 0, 3'b101, 32'h02, 0, 6), 32'h00008001, 0);
    add(mk(1, 0, 3'b010, 32'h00, 0, 6), 32'h80010000, 0);
    add(mk(1, 0, 3'b010, 32'h05, 0, 8), TRAP ? 32'h0 : 32'h1, TRAP);
    add(mk(0, 1, 3'b010, 32'h05, 32'h12345678, 0), 32'h0, TRAP);
    add(mk(1, 0, 3'b010, 32'h04, 0, 8), TRAP ? 32'h1 : 32'h12345678, 0);
    add(mk(0, 1, 3'b010, 32'(DEPTH * 4), 32'h00000BAD, 0), 32'h0, 1);
    add(mk(1, 0, 3'b010, 32'h00, 0, 9), 32'h80010000, 0);
    add(mk(1, 0, 3'b010, 32'(DEPTH * 4), 0, 9), 32'h0, 1);
    add(mk(1, 0, 3'b010, 32'h80000000, 0, 9), 32'h0, 1);
    add(mk(1, 1, 3'b010, 32'h30, 32'h55, 10), 32'h0, 0);
    add(mk(1, 0, 3'b010, 32'h30, 0, 10), 32'h55, 0);
    add(mk(0, 0, 3'b000, 32'h1234, 0, 7), 32'h0, 0);
    add(mk(1, 0, 3'b011, 32'h40, 0, 11), 32'hDEADBEEF, 0);
    add(mk(1, 0, 3'b000, 32'h43, 0, 12), 32'hFFFFFFDE, 0);
    add(mk(1, 0, 3'b101, 32'h42, 0, 13), 32'h0000DEAD, 0);
    add(mk(1, 0, 3'b001, 32'h43, 0, 14), TRAP ? 32'h0 : 32'hFFFFDEAD, TRAP);

    mdl_init();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb0", {rw0, m2r0, wmd0, walu0, wrd0}, 71'd0);
    chk("rst_wb3", {rw3, m2r3, wmd3, walu3, wrd3}, 71'd0);
    chk("rst_stall3", stall3, 1'b0);
    chk("rst_fault3", fault3, 1'b0);
    chk("rst_md3", md3, 32'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].exp_md, tbl[i].exp_fault);

    // Reset while the three-wait unit is partway through a store.
    op_no++;
    step(mk(0, 1, 3'b010, 32'h80, 32'hCAFEBABE, 0), 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_pending();
    ex = '0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_stall3", stall3, 1'b0);
    chk("midrst_wb3", {rw3, m2r3, wmd3, walu3, wrd3}, 71'd0);
    chk("midrst_wb0", {rw0, m2r0, wmd0, walu0, wrd0}, 71'd0);
    reset_n = 1'b1;
    pend = 1'b0;
    mdl_init();
    run_op(mk(1, 0, 3'b010, 32'h80, 0, 9), 32'h20, 0);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      x.alu_out = ($urandom_range(0, 7) == 0)
                  ? (($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 3000))
                                                 : ($urandom | 32'h80000000))
                  : 32'($urandom_range(0, 255));
      x.dataB      = $urandom;
      x.rd         = 5'($urandom_range(0, 31));
      x.mem_read   = (kind >= 1 && kind <= 4) || kind == 9;
      x.mem_write  = kind >= 5;
      x.mem_to_reg = x.mem_read;
      x.reg_write  = !x.mem_write;
      x.funct3     = x.mem_write ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
      run_op(x, mdl_md(x), mdl_fault(x));
    end

    @(negedge clk);
    check_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
